regfile_wr_arb: RTL and testbench

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

---
 rtl/regfile_wr_arb.sv | 214 +++++++++++++++++++++
 tb/tb_regfile_wr_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: two-requester write-back arbiter in front of a register file.
// The execute and memory stages each feed a small FIFO; a 1-bit round-robin
// pointer picks one head per cycle and loads it into the registered write port
// (we3/wa3/wd3). Writes to register 31 (XZR) are consumed but never emitted.
// Optional feature: define REGFILE_WR_ARB_PEND_EN to add the pend[31:0] output.

module regfile_wr_arb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [4:0]  push_addr,
  input  logic [63:0] push_data,
  input  logic        pop,
  output logic [4:0]  head_addr,
  output logic [63:0] head_data,
  output logic        empty,
  output logic        full
`ifdef REGFILE_WR_ARB_PEND_EN
  , output logic [31:0] addr_mask
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [63:0]   data_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_en, pop_en;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty;

  // Next-state for storage and pointers; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
    if (push_en) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // State registers; reset empties the FIFO and clears stale contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef REGFILE_WR_ARB_PEND_EN
  // One-hot OR of destination addresses of all occupied entries
  always_comb begin
    addr_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < count_q) begin
        addr_mask[addr_q[rd_ptr_q + PW'(k)]] = 1'b1;
      end
    end
  end
`endif

endmodule

module regfile_wr_arb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_wa,
  input  logic [63:0] ex_wd,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_wa,
  input  logic [63:0] mem_wd,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [63:0] wd3,
  output logic        idle
`ifdef REGFILE_WR_ARB_PEND_EN
  , output logic [31:0] pend
`endif
);

  logic        ex_empty, ex_full, mem_empty, mem_full;
  logic [4:0]  ex_head_addr, mem_head_addr;
  logic [63:0] ex_head_data, mem_head_data;
  logic        ex_grant, mem_grant, any_grant;
  logic [4:0]  grant_addr;
  logic [63:0] grant_data;
  logic        rr_q, rr_d;
  logic        we3_q, we3_d;
  logic [4:0]  wa3_q, wa3_d;
  logic [63:0] wd3_q, wd3_d;

`ifdef REGFILE_WR_ARB_PEND_EN
  logic [31:0] ex_mask, mem_mask;
`endif

  // Ready is a pure function of occupancy so a full FIFO never accepts, even when popping
  assign ex_ready  = !ex_full && !reset;
  assign mem_ready = !mem_full && !reset;

  regfile_wr_arb_fifo #(.DEPTH(DEPTH)) u_ex_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ex_valid && ex_ready),
    .push_addr (ex_wa),
    .push_data (ex_wd),
    .pop       (ex_grant),
    .head_addr (ex_head_addr),
    .head_data (ex_head_data),
    .empty     (ex_empty),
    .full      (ex_full)
`ifdef REGFILE_WR_ARB_PEND_EN
    , .addr_mask (ex_mask)
`endif
  );

  regfile_wr_arb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_valid && mem_ready),
    .push_addr (mem_wa),
    .push_data (mem_wd),
    .pop       (mem_grant),
    .head_addr (mem_head_addr),
    .head_data (mem_head_data),
    .empty     (mem_empty),
    .full      (mem_full)
`ifdef REGFILE_WR_ARB_PEND_EN
    , .addr_mask (mem_mask)
`endif
  );

  // Round-robin grant, pointer update and write-port next state (XZR writes are swallowed)
  always_comb begin
    ex_grant   = !ex_empty && (!rr_q || mem_empty);
    mem_grant  = !mem_empty && (rr_q || ex_empty);
    any_grant  = ex_grant || mem_grant;
    grant_addr = ex_grant ? ex_head_addr : mem_head_addr;
    grant_data = ex_grant ? ex_head_data : mem_head_data;
    rr_d       = rr_q;
    we3_d      = 1'b0;
    wa3_d      = wa3_q;
    wd3_d      = wd3_q;
    if (ex_grant) begin
      rr_d = 1'b1;
    end else if (mem_grant) begin
      rr_d = 1'b0;
    end
    if (any_grant && (grant_addr != 5'd31)) begin
      we3_d = 1'b1;
      wa3_d = grant_addr;
      wd3_d = grant_data;
    end
  end

  // Registered write port and arbitration pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q  <= 1'b0;
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else begin
      rr_q  <= rr_d;
      we3_q <= we3_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
    end
  end

  assign we3  = we3_q;
  assign wa3  = wa3_q;
  assign wd3  = wd3_q;
  assign idle = ex_empty && mem_empty && !we3_q;

`ifdef REGFILE_WR_ARB_PEND_EN
  // Pending writes: queued entries plus the write currently on the port; r31 is never pending
  assign pend = (ex_mask | mem_mask | (we3_q ? (32'h1 << wa3_q) : 32'h0)) & 32'h7FFF_FFFF;
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: directed self-checking bench for regfile_wr_arb (DEPTH=2).
// Define REGFILE_WR_ARB_PEND_EN to also exercise the pend output.

module tb_regfile_wr_arb;

  logic        clk;
  logic        reset;
  logic        ex_valid, mem_valid;
  logic        ex_ready, mem_ready;
  logic [4:0]  ex_wa, mem_wa;
  logic [63:0] ex_wd, mem_wd;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic        idle;
`ifdef REGFILE_WR_ARB_PEND_EN
  logic [31:0] pend;
`endif

  int pass_cnt;
  int total_cnt;

  regfile_wr_arb #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_wa     (ex_wa),
    .ex_wd     (ex_wd),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .idle      (idle)
`ifdef REGFILE_WR_ARB_PEND_EN
    , .pend    (pend)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total_cnt++; if ({we3, wa3, wd3} !== 70'd0) $display("[TB] FAIL reset_outputs: got we3=%0b wa3=%0d wd3=%0h expected 0/0/0", we3, wa3, wd3); else pass_cnt++;
    total_cnt++; if ({ex_ready, mem_ready} !== 2'b00) $display("[TB] FAIL reset_ready: got %b expected 00", {ex_ready, mem_ready}); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL reset_idle: got %0b expected 1", idle); else pass_cnt++;
    tick();
    reset = 1'b0;
    #1;
    total_cnt++; if ({ex_ready, mem_ready} !== 2'b11) $display("[TB] FAIL release_ready: got %b expected 11", {ex_ready, mem_ready}); else pass_cnt++;
    tick();
    total_cnt++; if (we3 !== 1'b0) $display("[TB] FAIL first_cycle_we3: got %0b expected 0", we3); else pass_cnt++;
  endtask

  task automatic test_single_write();
    ex_valid = 1'b1; ex_wa = 5'd5; ex_wd = 64'hAB;
    tick();
    ex_valid = 1'b0;
    total_cnt++; if ({we3, idle} !== 2'b00) $display("[TB] FAIL single_after_push: got we3=%0b idle=%0b expected 0/0", we3, idle); else pass_cnt++;
    tick();
    total_cnt++; if ({we3, wa3, wd3} !== {1'b1, 5'd5, 64'hAB}) $display("[TB] FAIL single_write: got we3=%0b wa3=%0d wd3=%0h expected 1/5/ab", we3, wa3, wd3); else pass_cnt++;
    tick();
    total_cnt++; if ({we3, idle, wa3} !== {1'b0, 1'b1, 5'd5}) $display("[TB] FAIL single_after: got we3=%0b idle=%0b wa3=%0d expected 0/1/5", we3, idle, wa3); else pass_cnt++;
  endtask

  task automatic test_xzr_drop();
    mem_valid = 1'b1; mem_wa = 5'd31; mem_wd = 64'hFF;
    tick();
    mem_valid = 1'b0;
    total_cnt++; if (idle !== 1'b0) $display("[TB] FAIL xzr_queued_idle: got %0b expected 0", idle); else pass_cnt++;
    tick();
    total_cnt++; if ({we3, wa3, wd3} !== {1'b0, 5'd5, 64'hAB}) $display("[TB] FAIL xzr_hold: got we3=%0b wa3=%0d wd3=%0h expected 0/5/ab", we3, wa3, wd3); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL xzr_consumed: got idle=%0b expected 1", idle); else pass_cnt++;
  endtask

  // The XZR grant went to mem, so ex must win first here
  task automatic test_contention();
    logic [4:0] ex_tab  [3];
    logic [4:0] mem_tab [3];
    logic [4:0] exp_wa  [6];
    logic [63:0] exp_wd [6];
    int ex_i, mem_i, got;
    logic ex_acc, mem_acc;
    ex_tab  = '{5'd1, 5'd2, 5'd3};
    mem_tab = '{5'd9, 5'd10, 5'd11};
    exp_wa  = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    exp_wd  = '{64'h101, 64'h209, 64'h102, 64'h20A, 64'h103, 64'h20B};
    ex_i = 0; mem_i = 0; got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      ex_valid  = (ex_i < 3);
      mem_valid = (mem_i < 3);
      if (ex_i < 3) begin ex_wa = ex_tab[ex_i]; ex_wd = 64'h100 + 64'(ex_tab[ex_i]); end
      if (mem_i < 3) begin mem_wa = mem_tab[mem_i]; mem_wd = 64'h200 + 64'(mem_tab[mem_i]); end
      ex_acc  = ex_valid && ex_ready;
      mem_acc = mem_valid && mem_ready;
      tick();
      if (ex_acc) ex_i++;
      if (mem_acc) mem_i++;
      if (we3 === 1'b1) begin
        total_cnt++; if ({wa3, wd3} !== {exp_wa[got], exp_wd[got]}) $display("[TB] FAIL contention_%0d: got wa3=%0d wd3=%0h expected %0d/%0h", got, wa3, wd3, exp_wa[got], exp_wd[got]); else pass_cnt++;
        got++;
      end
    end
    ex_valid = 1'b0; mem_valid = 1'b0;
    total_cnt++; if (got !== 6) $display("[TB] FAIL contention_count: got %0d writes expected 6", got); else pass_cnt++;
    tick();
    total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL contention_idle: got %0b expected 1", idle); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Lone ex write leaves the pointer on mem with both FIFOs empty
    ex_valid = 1'b1; ex_wa = 5'd4; ex_wd = 64'h4;
    tick();
    ex_valid = 1'b0;
    tick();
    total_cnt++; if ({we3, wa3} !== {1'b1, 5'd4}) $display("[TB] FAIL bp_pre: got we3=%0b wa3=%0d expected 1/4", we3, wa3); else pass_cnt++;
    tick();
    ex_valid = 1'b1; ex_wa = 5'd20; ex_wd = 64'h1014;
    mem_valid = 1'b1; mem_wa = 5'd12; mem_wd = 64'h100C;
    tick();
    total_cnt++; if ({ex_ready, we3} !== 2'b10) $display("[TB] FAIL bp_first: got ex_ready=%0b we3=%0b expected 1/0", ex_ready, we3); else pass_cnt++;
    ex_wa = 5'd21; ex_wd = 64'h1015;
    mem_wa = 5'd13; mem_wd = 64'h100D;
    tick();
    total_cnt++; if (ex_ready !== 1'b0) $display("[TB] FAIL bp_full: got ex_ready=%0b expected 0", ex_ready); else pass_cnt++;
    total_cnt++; if ({we3, wa3, wd3} !== {1'b1, 5'd12, 64'h100C}) $display("[TB] FAIL bp_w12: got we3=%0b wa3=%0d wd3=%0h expected 1/12/100c", we3, wa3, wd3); else pass_cnt++;
    ex_wa = 5'd22; ex_wd = 64'h1016;
    mem_wa = 5'd14; mem_wd = 64'h100E;
    tick();
    total_cnt++; if ({ex_ready, we3, wa3} !== {1'b1, 1'b1, 5'd20}) $display("[TB] FAIL bp_pop: got ex_ready=%0b we3=%0b wa3=%0d expected 1/1/20", ex_ready, we3, wa3); else pass_cnt++;
    mem_valid = 1'b0;
    tick();
    ex_valid = 1'b0;
    total_cnt++; if ({we3, wa3} !== {1'b1, 5'd13}) $display("[TB] FAIL bp_w13: got we3=%0b wa3=%0d expected 1/13", we3, wa3); else pass_cnt++;
    tick();
    total_cnt++; if ({we3, wa3, wd3} !== {1'b1, 5'd21, 64'h1015}) $display("[TB] FAIL bp_w21: got we3=%0b wa3=%0d wd3=%0h expected 1/21/1015", we3, wa3, wd3); else pass_cnt++;
    tick();
    total_cnt++; if ({we3, wa3} !== {1'b1, 5'd14}) $display("[TB] FAIL bp_w14: got we3=%0b wa3=%0d expected 1/14", we3, wa3); else pass_cnt++;
    tick();
    total_cnt++; if ({we3, wa3, wd3} !== {1'b1, 5'd22, 64'h1016}) $display("[TB] FAIL bp_w22: got we3=%0b wa3=%0d wd3=%0h expected 1/22/1016", we3, wa3, wd3); else pass_cnt++;
    tick();
    total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL bp_idle: got %0b expected 1", idle); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic saw_we3;
    ex_valid = 1'b1; ex_wa = 5'd6; ex_wd = 64'h66;
    mem_valid = 1'b1; mem_wa = 5'd7; mem_wd = 64'h77;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    total_cnt++; if ({we3, wa3, wd3} !== 70'd0) $display("[TB] FAIL midreset_out: got we3=%0b wa3=%0d wd3=%0h expected 0/0/0", we3, wa3, wd3); else pass_cnt++;
    total_cnt++; if ({ex_ready, mem_ready} !== 2'b00) $display("[TB] FAIL midreset_ready: got %b expected 00", {ex_ready, mem_ready}); else pass_cnt++;
    ex_valid = 1'b0; mem_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    saw_we3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (we3 !== 1'b0) saw_we3 = 1'b1;
    end
    total_cnt++; if (saw_we3 !== 1'b0) $display("[TB] FAIL midreset_nowrite: got we3 pulse=%0b expected 0", saw_we3); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL midreset_idle: got %0b expected 1", idle); else pass_cnt++;
  endtask

`ifdef REGFILE_WR_ARB_PEND_EN
  task automatic test_pend();
    total_cnt++; if (pend !== 32'h0) $display("[TB] FAIL pend_before: got %h expected 00000000", pend); else pass_cnt++;
    ex_valid = 1'b1; ex_wa = 5'd7; ex_wd = 64'h7;
    tick();
    ex_valid = 1'b0;
    total_cnt++; if (pend !== 32'h0000_0080) $display("[TB] FAIL pend_queued: got %h expected 00000080", pend); else pass_cnt++;
    tick();
    total_cnt++; if ({we3, wa3, pend} !== {1'b1, 5'd7, 32'h0000_0080}) $display("[TB] FAIL pend_port: got we3=%0b wa3=%0d pend=%h expected 1/7/00000080", we3, wa3, pend); else pass_cnt++;
    tick();
    total_cnt++; if (pend !== 32'h0) $display("[TB] FAIL pend_after: got %h expected 00000000", pend); else pass_cnt++;
    mem_valid = 1'b1; mem_wa = 5'd31; mem_wd = 64'h1;
    tick();
    mem_valid = 1'b0;
    total_cnt++; if (pend !== 32'h0) $display("[TB] FAIL pend_xzr: got %h expected 00000000", pend); else pass_cnt++;
    tick();
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    ex_valid  = 1'b0; ex_wa  = '0; ex_wd  = '0;
    mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
    #2;
    test_reset();
    test_single_write();
    test_xzr_drop();
    test_contention();
    test_back_to_back();
    test_reset_mid();
`ifdef REGFILE_WR_ARB_PEND_EN
    test_pend();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
